// File: rtl/random_delay_timer.sv
// Random red-to-green wait for the reaction game: draws MIN_MS + lfsr[RANGE_BITS-1:0]
// millisecond ticks when enabled, counts them down, then flags done until enable drops.
module random_delay_timer #(
  parameter int              TICK_DIV   = 50000,
  parameter int              MIN_MS     = 1000,
  parameter int              RANGE_BITS = 11,
  parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
  input  logic        Clock,
  input  logic        CLRN,
  input  logic        delayCounterEnable,
  output logic        delayCounterDone,
  output logic        busy,
  output logic [12:0] remainingTicks,
  output logic [15:0] randomValue
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [12:0]     MIN_CNT   = 13'(MIN_MS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [15:0]    lfsr_reg, lfsr_next;
  logic [12:0]    count_reg, count_next;
  logic [PW-1:0]  pre_reg, pre_next;
  logic           fb;

  // Free-running, so the drawn delay depends on when the player pressed start.
  assign fb        = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign lfsr_next = {lfsr_reg[14:0], fb};

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      state_reg <= IDLE;
      lfsr_reg  <= LFSR_SEED;
      count_reg <= '0;
      pre_reg   <= '0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      count_reg <= count_next;
      pre_reg   <= pre_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    pre_next   = pre_reg;
    case (state_reg)
      IDLE: begin
        if (delayCounterEnable) begin
          count_next = MIN_CNT + 13'(lfsr_reg[RANGE_BITS-1:0]);
          pre_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!delayCounterEnable) begin
          state_next = IDLE;
          count_next = '0;
          pre_next   = '0;
        end else if (pre_reg == TICK_LAST) begin
          // count is at least 1 in RUN, so this never wraps.
          pre_next   = '0;
          count_next = count_reg - 13'd1;
          if (count_reg == 13'd1) state_next = DONE;
        end else begin
          pre_next = pre_reg + PW'(1);
        end
      end
      DONE: begin
        // Holding enable keeps DONE; a fresh draw needs a pass through IDLE.
        if (!delayCounterEnable) begin
          state_next = IDLE;
          count_next = '0;
          pre_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        pre_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy             = (state_reg == RUN);
    delayCounterDone = (state_reg == DONE);
    remainingTicks   = count_reg;
    randomValue      = lfsr_reg;
  end

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed bench for random_delay_timer: LFSR sequence, nominal countdown, abort,
// re-arm, single-tick boundary and asynchronous reset mid-count.
module tb_random_delay_timer;

  logic        clk;
  logic        rst_n;
  logic        en_a, en_b;
  logic        done_a, busy_a, done_b, busy_b;
  logic [12:0] rem_a, rem_b;
  logic [15:0] rand_a, rand_b;
  logic [15:0] m_lfsr;
  int          checks;
  int          errors;
  logic [12:0] exp_cnt;

  random_delay_timer #(.TICK_DIV(4), .MIN_MS(3), .RANGE_BITS(2), .LFSR_SEED(16'hACE1)) dut_a (
    .Clock(clk), .CLRN(rst_n), .delayCounterEnable(en_a),
    .delayCounterDone(done_a), .busy(busy_a), .remainingTicks(rem_a), .randomValue(rand_a)
  );

  random_delay_timer #(.TICK_DIV(1), .MIN_MS(1), .RANGE_BITS(2), .LFSR_SEED(16'hACE1)) dut_b (
    .Clock(clk), .CLRN(rst_n), .delayCounterEnable(en_b),
    .delayCounterDone(done_b), .busy(busy_b), .remainingTicks(rem_b), .randomValue(rand_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR, x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Wait (bounded) at a falling edge until the pre-edge LFSR low bits match.
  task automatic wait_lfsr(input logic [1:0] want);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_lfsr[1:0] == want) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_lfsr_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rand_a", 32'(rand_a), 32'hACE1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_rem_a",  32'(rem_a),  32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_done_b", 32'(done_b), 32'd0);
    check("rst_rem_b",  32'(rem_b),  32'd0);
    rst_n = 1'b1;
    #1 check("release_rand", 32'(rand_a), 32'hACE1);
    @(negedge clk);
    check("lfsr_first_step", 32'(rand_a), 32'h59C3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("lfsr_seq_a", 32'(rand_a), 32'(m_lfsr));
      check("lfsr_seq_b", 32'(rand_b), 32'(m_lfsr));
    end
    $display("[%0t] lfsr sequence phase done", $time);

    // Nominal: load 3+1=4, 16 edges to done
    wait_lfsr(2'b01);
    en_a = 1'b1;
    @(negedge clk);
    check("nom_load_rem",  32'(rem_a),  32'd4);
    check("nom_load_busy", 32'(busy_a), 32'd1);
    check("nom_load_done", 32'(done_a), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("nom_rem",  32'(rem_a),  32'(4 - k / 4));
      check("nom_busy", 32'(busy_a), (k < 16) ? 32'd1 : 32'd0);
      check("nom_done", 32'(done_a), (k == 16) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_done",   32'(done_a), 32'd1);
      check("hold_noload", 32'(rem_a),  32'd0);
    end
    $display("[%0t] nominal countdown phase done", $time);

    // Re-arm after a one-edge drop
    en_a = 1'b0;
    @(negedge clk);
    check("rearm_drop_done", 32'(done_a), 32'd0);
    check("rearm_drop_busy", 32'(busy_a), 32'd0);
    exp_cnt = 13'd3 + 13'(m_lfsr[1:0]);
    en_a = 1'b1;
    @(negedge clk);
    check("rearm_rem",  32'(rem_a),  32'(exp_cnt));
    check("rearm_busy", 32'(busy_a), 32'd1);
    en_a = 1'b0;
    @(negedge clk);
    check("rearm_exit_busy", 32'(busy_a), 32'd0);
    $display("[%0t] re-arm phase done, loaded %0d", $time, exp_cnt);

    // Abort six edges after the load
    wait_lfsr(2'b01);
    en_a = 1'b1;
    @(negedge clk);
    check("abort_load_rem", 32'(rem_a), 32'd4);
    repeat (5) @(negedge clk);
    check("abort_mid_rem", 32'(rem_a), 32'd3);
    en_a = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_rem",  32'(rem_a),  32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done_a), 32'd0);
    end
    $display("[%0t] abort phase done", $time);

    // Boundary: TICK_DIV=1, MIN_MS=1, lfsr[1:0]=0 -> count 1, done next edge
    wait_lfsr(2'b00);
    en_b = 1'b1;
    @(negedge clk);
    check("bnd_load_rem",  32'(rem_b),  32'd1);
    check("bnd_load_busy", 32'(busy_b), 32'd1);
    check("bnd_load_done", 32'(done_b), 32'd0);
    @(negedge clk);
    check("bnd_done", 32'(done_b), 32'd1);
    check("bnd_busy", 32'(busy_b), 32'd0);
    check("bnd_rem",  32'(rem_b),  32'd0);
    en_b = 1'b0;
    @(negedge clk);
    check("bnd_exit_done", 32'(done_b), 32'd0);
    $display("[%0t] boundary phase done", $time);

    // Asynchronous reset while counting
    en_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("areset_pre_busy", 32'(busy_a), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy_a), 32'd0);
    check("areset_rem",  32'(rem_a),  32'd0);
    check("areset_done", 32'(done_a), 32'd0);
    check("areset_rand", 32'(rand_a), 32'hACE1);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("areset_rel_busy", 32'(busy_a), 32'd0);
    check("areset_rel_rem",  32'(rem_a),  32'd0);
    @(negedge clk);
    check("areset_step_rand", 32'(rand_a), 32'h59C3);
    check("areset_idle_busy", 32'(busy_a), 32'd0);
    $display("[%0t] async reset phase done", $time);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
